// File: rtl/uart_tx_ctrl_if.sv
// CPU-side bus of the UART transmitter: TXREG write strobe/data and the two status flags.
interface uart_tx_ctrl_if;
  logic [7:0] data_bus;
  logic       write_en;
  logic       TXIF;
  logic       TRMT;

  modport master (output data_bus, write_en, input TXIF, TRMT);
  modport slave  (input data_bus, write_en, output TXIF, TRMT);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: TXREG holding register feeding a TSR that shifts out 8N1 frames on TX.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_ctrl #(
  parameter int DIV_50MHZ  = 5208,
  parameter int DIV_100MHZ = 10417,
  parameter int CNT_W      = 14
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           EN_50MHz,
  input  logic           SPEN,
  input  logic           TXEN,
  uart_tx_ctrl_if.slave  bus,
  output logic           TX
);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_W-1:0] DIV50_M1  = CNT_W'(DIV_50MHZ - 1);
  localparam logic [CNT_W-1:0] DIV100_M1 = CNT_W'(DIV_100MHZ - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [CNT_W-1:0] div_m1, div_m1_n;
  logic [2:0]       bit_idx, bit_idx_n, idx_inc;
  logic [7:0]       txreg, txreg_n;
  logic [7:0]       tsr, tsr_n;
  logic             txif, txif_n;
  logic             tx_q, tx_n;
  logic             baud_tick, start_ok, load_frame;

  assign baud_tick  = (baud_cnt == div_m1);
  assign start_ok   = !txif && SPEN && TXEN;
  // A new frame starts from IDLE or directly at the end of a stop bit (no idle gap).
  assign load_frame = start_ok && ((state == IDLE) || ((state == STOP) && baud_tick));
  assign idx_inc    = bit_idx + 3'd1;

  assign TX       = tx_q;
  assign bus.TXIF = txif;
  assign bus.TRMT = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_m1   <= DIV50_M1;
      bit_idx  <= '0;
      txreg    <= '0;
      tsr      <= '0;
      txif     <= 1'b1;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      div_m1   <= div_m1_n;
      bit_idx  <= bit_idx_n;
      txreg    <= txreg_n;
      tsr      <= tsr_n;
      txif     <= txif_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    div_m1_n   = div_m1;
    bit_idx_n  = bit_idx;
    txreg_n    = txreg;
    tsr_n      = tsr;
    txif_n     = txif;
    tx_n       = tx_q;

    // Writes are accepted regardless of SPEN; a full TXREG silently drops them.
    if (bus.write_en && txif) begin
      txreg_n = bus.data_bus;
      txif_n  = 1'b0;
    end

    if (!SPEN) begin
      state_n    = IDLE;
      tx_n       = 1'b1;
      baud_cnt_n = '0;
      bit_idx_n  = '0;
    end else begin
      if (state != IDLE)
        baud_cnt_n = baud_tick ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          baud_cnt_n = '0;
          tx_n       = 1'b1;
        end
        START: begin
          if (baud_tick) begin
            state_n   = DATA;
            bit_idx_n = '0;
            tx_n      = tsr[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
              state_n = PARITY;
              tx_n    = ^tsr;
`else
              state_n = STOP;
              tx_n    = 1'b1;
`endif
            end else begin
              bit_idx_n = idx_inc;
              tx_n      = tsr[idx_inc];
            end
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      endcase

      // The bit period is captured here so EN_50MHz changes mid-frame are harmless.
      if (load_frame) begin
        tsr_n      = txreg;
        txif_n     = 1'b1;
        state_n    = START;
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        tx_n       = 1'b0;
        div_m1_n   = EN_50MHz ? DIV50_M1 : DIV100_M1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: frame-level reference model checked every cycle, plus directed literals.
module tb_uart_tx_ctrl;
  localparam int D50  = 4;
  localparam int D100 = 8;
`ifdef TX_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en_50mhz, spen, txen;
  logic tx;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  bit cmp_en   = 1'b0;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.DIV_50MHZ(D50), .DIV_100MHZ(D100), .CNT_W(14)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .EN_50MHz (en_50mhz),
    .SPEN     (spen),
    .TXEN     (txen),
    .bus      (bus),
    .TX       (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: a frame is a list of line levels, each held for m_div cycles.
  bit         m_busy      = 1'b0;
  bit         m_hold_full = 1'b0;
  logic [7:0] m_hold      = 8'h00;
  logic       m_bits [0:10];
  int         m_pos = 0, m_cyc = 0, m_div = D50;
  int         m_frame_count = 0;
  bit         m_wr_ok, m_go;
  logic       exp_tx;

  task automatic model_start();
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[1+i] = m_hold[i];
`ifdef TX_PARITY_EN
    m_bits[9]  = ^m_hold;
    m_bits[10] = 1'b1;
`else
    m_bits[9]  = 1'b1;
    m_bits[10] = 1'b1;
`endif
    m_busy      = 1'b1;
    m_pos       = 0;
    m_cyc       = 0;
    m_div       = en_50mhz ? D50 : D100;
    m_hold_full = 1'b0;
    m_frame_count++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      = 1'b0;
      m_hold_full = 1'b0;
      m_hold      = 8'h00;
      m_pos       = 0;
      m_cyc       = 0;
    end else begin
      m_wr_ok = bus.write_en && !m_hold_full;
      m_go    = m_hold_full && spen && txen;
      if (!spen) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_cyc++;
        if (m_cyc == m_div) begin
          m_cyc = 0;
          m_pos++;
          if (m_pos == FRAME_LEN) begin
            m_busy = 1'b0;
            if (m_go) model_start();
          end
        end
      end else if (m_go) begin
        model_start();
      end
      if (m_wr_ok) begin
        m_hold      = bus.data_bus;
        m_hold_full = 1'b1;
      end
    end
  end

  assign exp_tx = m_busy ? m_bits[m_pos] : 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      checkOutput("model_tx",   tx,       exp_tx);
      checkOutput("model_txif", bus.TXIF, !m_hold_full);
      checkOutput("model_trmt", bus.TRMT, !m_busy);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    bus.data_bus = d;
    bus.write_en = 1'b1;
    step(1);
    bus.write_en = 1'b0;
  endtask

  // Waits for the model to launch frame number 'target', then samples each data bit mid-period.
  task automatic capture_byte(input int target, input int div, output logic [7:0] b, output int start);
    int n = 0;
    b = 8'h00;
    while (m_frame_count < target && n < 500) begin
      step(1);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("[TB] FAIL frame_start_timeout: got none expected frame %0d", target);
    end
    start = cyc_cnt;
    checkOutput("start_bit", tx, 1'b0);
    step(div + div / 2);
    for (int i = 0; i < 8; i++) begin
      b[i] = tx;
      if (i < 7) step(div);
    end
  endtask

  task automatic wait_idle(output int at);
    int n = 0;
    while (!(bus.TRMT === 1'b1 && bus.TXIF === 1'b1) && n < 400) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("[TB] FAIL idle_timeout: got trmt=%0b txif=%0b expected 1/1", bus.TRMT, bus.TXIF);
    end
    at = cyc_cnt;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:10] pat55;
    logic [7:0]  b1, b2;
    int          s1, s2, t_end, n0;

`ifdef TX_PARITY_EN
    pat55 = 11'b01010101001;
`else
    pat55 = 11'b01010101011;
`endif
    bus.data_bus = 8'h00;
    bus.write_en = 1'b0;
    en_50mhz = 1'b1;
    spen     = 1'b1;
    txen     = 1'b1;
    rst_n    = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    checkOutput("rst_tx",   tx,       1'b1);
    checkOutput("rst_txif", bus.TXIF, 1'b1);
    checkOutput("rst_trmt", bus.TRMT, 1'b1);
    step(1);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    $display("[TB] idle after reset");
    step(100);
    checkOutput("idle100_tx",   tx,       1'b1);
    checkOutput("idle100_txif", bus.TXIF, 1'b1);
    checkOutput("idle100_trmt", bus.TRMT, 1'b1);

    $display("[TB] single frame 0x55");
    applyStimulus(8'h55);
    checkOutput("w55_txif_k", bus.TXIF, 1'b0);
    checkOutput("w55_trmt_k", bus.TRMT, 1'b1);
    step(1);
    checkOutput("w55_txif_k1", bus.TXIF, 1'b1);
    checkOutput("w55_trmt_k1", bus.TRMT, 1'b0);
    step(1);
    for (int b = 0; b < FRAME_LEN; b++) begin
      checkOutput("w55_bit", tx, pat55[b]);
      if (b < FRAME_LEN - 1) step(4);
    end
    step(2);
    checkOutput("w55_trmt_last", bus.TRMT, 1'b0);
    step(1);
    checkOutput("w55_trmt_done", bus.TRMT, 1'b1);

    $display("[TB] back-to-back 0xA3 0x0F");
    n0 = m_frame_count;
    applyStimulus(8'hA3);
    capture_byte(n0 + 1, D50, b1, s1);
    checkOutput("b2b_first", b1, 8'hA3);
    applyStimulus(8'h0F);
    capture_byte(n0 + 2, D50, b2, s2);
    checkOutput("b2b_second", b2, 8'h0F);
    checkOutput("b2b_spacing", s2 - s1, 4 * FRAME_LEN);
    wait_idle(t_end);

    $display("[TB] write to full TXREG ignored");
    n0 = m_frame_count;
    applyStimulus(8'h3C);
    step(1);
    applyStimulus(8'h5A);
    step(2);
    applyStimulus(8'hFF);
    checkOutput("ign_txif", bus.TXIF, 1'b0);
    capture_byte(n0 + 2, D50, b1, s1);
    checkOutput("ign_held_byte", b1, 8'h5A);
    wait_idle(t_end);

    $display("[TB] SPEN drop during data bit 3");
    n0 = m_frame_count;
    applyStimulus(8'h96);
    step(1);
    applyStimulus(8'h69);
    step(16);
    checkOutput("spen_bit3", tx, 1'b0);
    spen = 1'b0;
    step(1);
    checkOutput("spen_tx",   tx,       1'b1);
    checkOutput("spen_trmt", bus.TRMT, 1'b1);
    checkOutput("spen_txif", bus.TXIF, 1'b0);
    step(10);
    spen = 1'b1;
    capture_byte(n0 + 2, D50, b1, s1);
    checkOutput("spen_pending", b1, 8'h69);
    wait_idle(t_end);

    $display("[TB] TXEN gating");
    txen = 1'b0;
    applyStimulus(8'h3E);
    step(20);
    checkOutput("txen_trmt", bus.TRMT, 1'b1);
    checkOutput("txen_txif", bus.TXIF, 1'b0);
    n0 = m_frame_count;
    txen = 1'b1;
    capture_byte(n0 + 1, D50, b1, s1);
    checkOutput("txen_byte", b1, 8'h3E);
    wait_idle(t_end);

    $display("[TB] 100 MHz divider with mid-frame toggle");
    en_50mhz = 1'b0;
    n0 = m_frame_count;
    applyStimulus(8'hC5);
    fork
      capture_byte(n0 + 1, D100, b1, s1);
      begin
        step(20);
        en_50mhz = 1'b1;
      end
    join
    checkOutput("div100_byte", b1, 8'hC5);
    wait_idle(t_end);
    checkOutput("div100_len", t_end - s1, 8 * FRAME_LEN);

`ifdef TX_PARITY_EN
    $display("[TB] parity bits");
    n0 = m_frame_count;
    applyStimulus(8'h07);
    capture_byte(n0 + 1, D50, b1, s1);
    step(4);
    checkOutput("parity_07", tx, 1'b1);
    wait_idle(t_end);
    n0 = m_frame_count;
    applyStimulus(8'h03);
    capture_byte(n0 + 1, D50, b1, s1);
    step(4);
    checkOutput("parity_03", tx, 1'b0);
    wait_idle(t_end);
`endif

    $display("[TB] reset mid-frame");
    applyStimulus(8'hE7);
    step(1);
    applyStimulus(8'h18);
    step(8);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_tx",   tx,       1'b1);
    checkOutput("midrst_txif", bus.TXIF, 1'b1);
    checkOutput("midrst_trmt", bus.TRMT, 1'b1);
    step(2);
    rst_n = 1'b1;
    step(10);
    checkOutput("postrst_tx",   tx,       1'b1);
    checkOutput("postrst_trmt", bus.TRMT, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
